// File: rtl/spi_controller_if.sv
// Command handshake bundle for spi_controller.
//   cmd_valid : requester has a command on cmd_rw/cmd_addr/cmd_data
//   cmd_ready : controller can take a command this cycle
//   cmd_rw    : frame bit 15 (1 = write)
//   cmd_addr  : register address, frame bits 14:8
//   cmd_data  : write data, frame bits 7:0
// master = command source, slave = the controller.
interface spi_controller_if;
  logic       cmd_valid;
  logic       cmd_ready;
  logic       cmd_rw;
  logic [6:0] cmd_addr;
  logic [7:0] cmd_data;

  modport master (
    output cmd_valid, cmd_rw, cmd_addr, cmd_data,
    input  cmd_ready
  );

  modport slave (
    input  cmd_valid, cmd_rw, cmd_addr, cmd_data,
    output cmd_ready
  );
endinterface

// File: rtl/spi_controller.sv
// SPI mode-0 register-command controller.
// Takes one command per valid/ready handshake and sends it as a 16-bit
// frame, MSB first: {rw, addr[6:0], data[7:0]}. All SPI timing comes from clk.
// Ports:
//   clk, rst : system clock, synchronous active-high reset
//   cmd      : command handshake (spi_controller_if.slave)
//   busy     : high in every state other than IDLE
//   done     : one-cycle pulse on the first cycle nCS is high again
//   SCLK     : SPI clock, idles low
//   nCS      : chip select, active low
//   COPI     : serial data out
// All outputs are registered.
module spi_controller #(
  parameter int CLK_DIV  = 4,  // clk cycles per SCLK half-period (2..255)
  parameter int CS_SETUP = 4,  // nCS low before the first shift phase (2..255)
  parameter int CS_HOLD  = 4,  // nCS low after the last SCLK fall (2..255)
  parameter int IDLE_GAP = 4   // minimum nCS high between frames (2..255)
) (
  input  logic              clk,
  input  logic              rst,
  spi_controller_if.slave   cmd,
  output logic              busy,
  output logic              done,
  output logic              SCLK,
  output logic              nCS,
  output logic              COPI
);

  typedef enum logic [2:0] {IDLE, SETUP, SHIFT, HOLD, GAP} state_t;

  // Phase counters run 0 .. N-1, so compare against N-1.
  localparam logic [7:0] DIV_LAST   = 8'(CLK_DIV - 1);
  localparam logic [7:0] SETUP_LAST = 8'(CS_SETUP - 1);
  localparam logic [7:0] HOLD_LAST  = 8'(CS_HOLD - 1);
  localparam logic [7:0] GAP_LAST   = 8'(IDLE_GAP - 1);

  state_t      state_reg;
  logic [7:0]  phase_cnt_reg;
  logic [3:0]  bit_cnt_reg;
  logic [15:0] shift_reg;
  logic        ready_reg;
  logic        busy_reg;
  logic        done_reg;
  logic        sclk_reg;
  logic        ncs_reg;
  logic        copi_reg;

  assign cmd.cmd_ready = ready_reg;
  assign busy          = busy_reg;
  assign done          = done_reg;
  assign SCLK          = sclk_reg;
  assign nCS           = ncs_reg;
  assign COPI          = copi_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg     <= IDLE;
      phase_cnt_reg <= 8'd0;
      bit_cnt_reg   <= 4'd0;
      shift_reg     <= 16'd0;
      ready_reg     <= 1'b1;
      busy_reg      <= 1'b0;
      done_reg      <= 1'b0;
      sclk_reg      <= 1'b0;
      ncs_reg       <= 1'b1;
      copi_reg      <= 1'b0;
    end else begin
      done_reg <= 1'b0;
      unique case (state_reg)
        IDLE: begin
          if (cmd.cmd_valid && ready_reg) begin
            shift_reg     <= {cmd.cmd_rw, cmd.cmd_addr, cmd.cmd_data};
            copi_reg      <= cmd.cmd_rw;  // bit 15 is on the line from nCS fall
            ncs_reg       <= 1'b0;
            sclk_reg      <= 1'b0;
            busy_reg      <= 1'b1;
            ready_reg     <= 1'b0;
            phase_cnt_reg <= 8'd0;
            state_reg     <= SETUP;
          end
        end

        SETUP: begin
          if (phase_cnt_reg == SETUP_LAST) begin
            phase_cnt_reg <= 8'd0;
            state_reg     <= SHIFT;
          end else begin
            phase_cnt_reg <= phase_cnt_reg + 8'd1;
          end
        end

        // sclk_reg itself tells which half of the bit we are in. COPI is only
        // touched on the high->low transition, i.e. at the start of a low phase.
        SHIFT: begin
          if (phase_cnt_reg == DIV_LAST) begin
            phase_cnt_reg <= 8'd0;
            if (!sclk_reg) begin
              sclk_reg <= 1'b1;
            end else begin
              sclk_reg <= 1'b0;
              if (bit_cnt_reg == 4'd15) begin
                bit_cnt_reg <= 4'd0;
                state_reg   <= HOLD;
              end else begin
                bit_cnt_reg <= bit_cnt_reg + 4'd1;
                shift_reg   <= {shift_reg[14:0], 1'b0};
                copi_reg    <= shift_reg[14];
              end
            end
          end else begin
            phase_cnt_reg <= phase_cnt_reg + 8'd1;
          end
        end

        HOLD: begin
          if (phase_cnt_reg == HOLD_LAST) begin
            phase_cnt_reg <= 8'd0;
            ncs_reg       <= 1'b1;
            copi_reg      <= 1'b0;
            done_reg      <= 1'b1;
            state_reg     <= GAP;
          end else begin
            phase_cnt_reg <= phase_cnt_reg + 8'd1;
          end
        end

        GAP: begin
          if (phase_cnt_reg == GAP_LAST) begin
            phase_cnt_reg <= 8'd0;
            busy_reg      <= 1'b0;
            ready_reg     <= 1'b1;
            state_reg     <= IDLE;
          end else begin
            phase_cnt_reg <= phase_cnt_reg + 8'd1;
          end
        end

        default: begin
          state_reg <= IDLE;
          ready_reg <= 1'b1;
          busy_reg  <= 1'b0;
          ncs_reg   <= 1'b1;
          sclk_reg  <= 1'b0;
          copi_reg  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_spi_controller.sv
// Bench for spi_controller: instance A uses default timing, instance B the
// minimum legal timing (all 2). A negedge monitor decodes frames from the
// selected instance; a small 8-register stand-in peripheral applies decoded
// writes (addresses >= 8 are ignored) and is compared to a reference bank.
module tb_spi_controller;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       sel = 1'b0;   // 0 = instance A, 1 = instance B
  logic       cmd_valid = 1'b0;
  logic       cmd_rw = 1'b0;
  logic [6:0] cmd_addr = 7'd0;
  logic [7:0] cmd_data = 8'd0;

  always #5 clk = ~clk;

  spi_controller_if ia();
  spi_controller_if ib();
  assign ia.cmd_valid = cmd_valid & ~sel;
  assign ib.cmd_valid = cmd_valid & sel;
  assign ia.cmd_rw = cmd_rw;    assign ib.cmd_rw = cmd_rw;
  assign ia.cmd_addr = cmd_addr; assign ib.cmd_addr = cmd_addr;
  assign ia.cmd_data = cmd_data; assign ib.cmd_data = cmd_data;

  logic busy_a, done_a, sclk_a, ncs_a, copi_a;
  logic busy_b, done_b, sclk_b, ncs_b, copi_b;

  spi_controller #(.CLK_DIV(4), .CS_SETUP(4), .CS_HOLD(4), .IDLE_GAP(4)) dut_a (
    .clk(clk), .rst(rst), .cmd(ia), .busy(busy_a), .done(done_a),
    .SCLK(sclk_a), .nCS(ncs_a), .COPI(copi_a));

  spi_controller #(.CLK_DIV(2), .CS_SETUP(2), .CS_HOLD(2), .IDLE_GAP(2)) dut_b (
    .clk(clk), .rst(rst), .cmd(ib), .busy(busy_b), .done(done_b),
    .SCLK(sclk_b), .nCS(ncs_b), .COPI(copi_b));

  logic m_busy, m_done, m_sclk, m_ncs, m_copi, m_ready, m_valid;
  assign m_busy  = sel ? busy_b : busy_a;
  assign m_done  = sel ? done_b : done_a;
  assign m_sclk  = sel ? sclk_b : sclk_a;
  assign m_ncs   = sel ? ncs_b  : ncs_a;
  assign m_copi  = sel ? copi_b : copi_a;
  assign m_ready = sel ? ib.cmd_ready : ia.cmd_ready;
  assign m_valid = sel ? ib.cmd_valid : ia.cmd_valid;

  // ---------------- checking ----------------
  int n_compared = 0;
  int n_mismatched = 0;

  task automatic check_value(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_compared++;
    if (got !== exp) begin
      n_mismatched++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // ---------------- monitor ----------------
  typedef struct {
    logic [15:0] bits;
    int          low_len;
    int          rises;
    int          copi_viol;
    int          rdy_viol;
    int          gap_before;
    bit          done_at_rise;
  } frame_t;

  frame_t frames[$];
  int     acc_q[$];
  frame_t cur;
  bit     in_frame = 1'b0;
  int     cyc = 0;
  int     hi_len = 0;
  int     done_cnt = 0;
  logic   prev_sclk = 1'b0;
  logic   prev_copi = 1'b0;
  logic [7:0] obs_bank [8];
  logic [7:0] ref_bank [8];

  always @(negedge clk) begin
    cyc++;
    if (rst) begin
      in_frame  = 1'b0;
      hi_len    = 0;
      prev_sclk = 1'b0;
      prev_copi = 1'b0;
    end else begin
      if (m_valid && m_ready) acc_q.push_back(cyc);
      if (!m_ncs) begin
        if (!in_frame) begin
          in_frame = 1'b1;
          cur.bits = 16'd0; cur.low_len = 0; cur.rises = 0;
          cur.copi_viol = 0; cur.rdy_viol = 0; cur.gap_before = hi_len;
          cur.done_at_rise = 1'b0;
          hi_len = 0;
        end
        cur.low_len++;
        if (m_sclk && !prev_sclk) begin
          cur.bits = {cur.bits[14:0], m_copi};
          cur.rises++;
        end
        if (m_sclk && prev_sclk && (m_copi !== prev_copi)) cur.copi_viol++;
        if (m_ready) cur.rdy_viol++;
      end else begin
        hi_len++;
        if (in_frame) begin
          in_frame = 1'b0;
          cur.done_at_rise = m_done;
          if (cur.bits[15] && cur.bits[14:8] < 7'd8) obs_bank[cur.bits[10:8]] = cur.bits[7:0];
          frames.push_back(cur);
        end
      end
      if (m_done) done_cnt++;
      prev_sclk = m_sclk;
      prev_copi = m_copi;
    end
  end

  // ---------------- reference model ----------------
  function automatic int exp_low_len();
    return sel ? (2 + 32 * 2 + 2) : (4 + 32 * 4 + 4);
  endfunction

  function automatic int exp_accept_gap();
    return sel ? (1 + 2 + 64 + 2 + 2) : (1 + 4 + 128 + 4 + 4);
  endfunction

  task automatic ref_apply(input logic rw, input logic [6:0] addr, input logic [7:0] data);
    if (rw && addr < 7'd8) ref_bank[addr[2:0]] = data;
  endtask

  task automatic check_bank(input string tag);
    for (int i = 0; i < 8; i++) check_value($sformatf("%s_reg%0d", tag, i), {24'd0, obs_bank[i]}, {24'd0, ref_bank[i]});
  endtask

  // ---------------- stimulus helpers ----------------
  task automatic wait_accept(input int n0);
    int k;
    for (k = 0; k < 1000; k++) begin
      @(negedge clk);
      if (acc_q.size() > n0) break;
    end
    if (k == 1000) check_value("accept_timeout", 32'd0, 32'd1);
  endtask

  task automatic send_cmd(input logic rw, input logic [6:0] addr, input logic [7:0] data);
    int n0;
    n0 = acc_q.size();
    @(posedge clk); #1;
    cmd_rw = rw; cmd_addr = addr; cmd_data = data; cmd_valid = 1'b1;
    wait_accept(n0);
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    // scramble the inputs: the frame in flight must not follow them
    cmd_rw = ~rw; cmd_addr = ~addr; cmd_data = ~data;
  endtask

  task automatic wait_frames(input int n);
    int k;
    for (k = 0; k < 2000; k++) begin
      @(negedge clk);
      if (frames.size() >= n) break;
    end
    if (k == 2000) check_value("frame_timeout", 32'd0, 32'd1);
  endtask

  task automatic check_frame(input string tag, input logic [15:0] exp_bits);
    frame_t f;
    if (frames.size() == 0) begin
      check_value({tag, "_missing"}, 32'd0, 32'd1);
      return;
    end
    f = frames.pop_front();
    check_value({tag, "_bits"}, {16'd0, f.bits}, {16'd0, exp_bits});
    check_value({tag, "_ncs_low"}, f.low_len, exp_low_len());
    check_value({tag, "_rises"}, f.rises, 32'd16);
    check_value({tag, "_done"}, {31'd0, f.done_at_rise}, 32'd1);
    check_value({tag, "_copi_stable"}, f.copi_viol, 32'd0);
    check_value({tag, "_ready_low"}, f.rdy_viol, 32'd0);
  endtask

  task automatic do_frame(input string tag, input logic rw, input logic [6:0] addr, input logic [7:0] data);
    int d0;
    d0 = done_cnt;
    send_cmd(rw, addr, data);
    wait_frames(1);
    check_frame(tag, {rw, addr, data});
    ref_apply(rw, addr, data);
    repeat (4) @(negedge clk);
    check_value({tag, "_done_count"}, done_cnt - d0, 32'd1);
    $display("frame %s rw=%0d addr=0x%02h data=0x%02h", tag, rw, addr, data);
  endtask

  // ---------------- test sequence ----------------
  initial begin
    logic [7:0]  lb_data [5];
    logic [15:0] c1, c2;
    int a0, d0, r, k;

    for (int i = 0; i < 8; i++) begin
      obs_bank[i] = 8'd0;
      ref_bank[i] = 8'd0;
    end
    lb_data[0] = 8'hA5; lb_data[1] = 8'h5A; lb_data[2] = 8'hFF;
    lb_data[3] = 8'h01; lb_data[4] = 8'h40;

    // reset, with cmd_valid asserted: rst must win
    cmd_valid = 1'b1; cmd_rw = 1'b1; cmd_addr = 7'h03; cmd_data = 8'h77;
    repeat (3) @(posedge clk);
    #1;
    check_value("rst_ncs", {31'd0, ncs_a}, 32'd1);
    check_value("rst_busy", {31'd0, busy_a}, 32'd0);
    cmd_valid = 1'b0;
    rst = 1'b0;
    @(posedge clk); #1;
    check_value("reset_sclk", {31'd0, sclk_a}, 32'd0);
    check_value("reset_ncs", {31'd0, ncs_a}, 32'd1);
    check_value("reset_copi", {31'd0, copi_a}, 32'd0);
    check_value("reset_done", {31'd0, done_a}, 32'd0);
    check_value("reset_busy", {31'd0, busy_a}, 32'd0);
    check_value("reset_ready", {31'd0, ia.cmd_ready}, 32'd1);
    check_value("reset_ready_b", {31'd0, ib.cmd_ready}, 32'd1);

    // directed write duty-cycle frame
    do_frame("write84", 1'b1, 7'h04, 8'h80);
    check_bank("after_write84");

    // loopback writes 0x00..0x04
    for (int i = 0; i < 5; i++) do_frame($sformatf("loop%0d", i), 1'b1, 7'(i), lb_data[i]);
    check_bank("after_loopback");

    // read frame and out-of-bank write
    do_frame("read00", 1'b0, 7'h00, 8'hFF);
    do_frame("write7f", 1'b1, 7'h7F, 8'($urandom_range(0, 255)));
    check_bank("after_read");

    // back-to-back with cmd_valid held high; second command appears after
    // the first accept, so the first frame must keep its own payload
    c1 = 16'($urandom); c2 = 16'($urandom);
    a0 = acc_q.size();
    @(posedge clk); #1;
    {cmd_rw, cmd_addr, cmd_data} = c1; cmd_valid = 1'b1;
    wait_accept(a0);
    @(posedge clk); #1;
    {cmd_rw, cmd_addr, cmd_data} = c2;
    wait_accept(a0 + 1);
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    if (acc_q.size() >= a0 + 2)
      check_value("b2b_accept_gap", acc_q[a0 + 1] - acc_q[a0], exp_accept_gap());
    wait_frames(2);
    check_frame("b2b_first", c1);
    if (frames.size() > 0)
      check_value("b2b_gap_min", {31'd0, frames[0].gap_before >= 4}, 32'd1);
    check_frame("b2b_second", c2);
    ref_apply(c1[15], c1[14:8], c1[7:0]);
    ref_apply(c2[15], c2[14:8], c2[7:0]);
    $display("back-to-back 0x%04h then 0x%04h", c1, c2);
    repeat (8) @(negedge clk);

    // random commands
    for (int i = 0; i < 8; i++)
      do_frame($sformatf("rand%0d", i), 1'($urandom), 7'($urandom_range(0, 15)), 8'($urandom));
    check_bank("after_random");

    // reset after the 5th SCLK rise
    d0 = done_cnt;
    a0 = acc_q.size();
    @(posedge clk); #1;
    cmd_rw = 1'b1; cmd_addr = 7'h05; cmd_data = 8'hEE; cmd_valid = 1'b1;
    wait_accept(a0);
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    r = 0;
    for (k = 0; k < 500 && r < 5; k++) begin
      @(negedge clk);
      if (m_sclk && !prev_sclk) r++;
    end
    check_value("midrst_rises_seen", r, 32'd5);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    check_value("midrst_ncs", {31'd0, ncs_a}, 32'd1);
    check_value("midrst_sclk", {31'd0, sclk_a}, 32'd0);
    check_value("midrst_copi", {31'd0, copi_a}, 32'd0);
    check_value("midrst_done", {31'd0, done_a}, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    repeat (20) @(negedge clk);
    check_value("midrst_no_done", done_cnt - d0, 32'd0);
    check_value("midrst_no_frame", frames.size(), 32'd0);
    $display("reset mid-shift after %0d rises", r);
    do_frame("post_rst", 1'b1, 7'h02, 8'h3C);
    check_bank("after_post_rst");

    // minimum timing instance
    sel = 1'b1;
    repeat (4) @(negedge clk);
    do_frame("min_timing", 1'b1, 7'h01, 8'hC3);
    check_value("min_reg1", {24'd0, obs_bank[1]}, 32'h0000_00C3);
    c1 = 16'($urandom);
    do_frame("min_rand", c1[15], c1[14:8], c1[7:0]);
    check_bank("after_min");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

  // absolute safety bound
  initial begin
    #2000000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
